// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, op encoding and FSM states for the calculator sequencer
// Contents: operand/result widths, op_sel encoding, blank digit code,
// sequencer state enum, and one double-dabble nibble-adjust helper.
package calc_pkg;

    localparam int OPND_W = 7;
    localparam int RES_W  = 14;
    localparam int BCD_W  = 16;

    localparam logic [1:0] OP_OFF  = 2'd0;
    localparam logic [1:0] OP_SOMA = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_MULT = 2'd3;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_CONV,
        ST_DONE
    } state_t;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_event.sv
// rtl/btn_event.sv - two-flop synchronizer plus falling-edge detector for one active-low button
// Ports:
//   clock  in  system clock
//   reset  in  synchronous active-high reset
//   btn_n  in  raw asynchronous active-low button
//   pulse  out one-cycle event per press, no repeat while held
module btn_event (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // Released level is 1, so the chain resets to 1 and a held-at-reset
    // button cannot fake a press.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
            pulse <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            prev  <= sync2;
            pulse <= prev & ~sync2;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - button handling, op select, arithmetic and BCD conversion for the calculator
// Ports:
//   clock, reset                         clock and synchronous active-high reset
//   botao, botaoSOMA, botaoSUB, botaoMULT raw active-low equals / op-select buttons
//   numero0, numero1                     7-bit unsigned operands
//   op_sel                               current op (0 off, 1 soma, 2 sub, 3 mult)
//   busy, result_valid, neg, ovf         status flags
//   milR, cenR, decR, uniR               BCD result digits
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int CONV_ITERS = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              botao,
    input  logic              botaoSOMA,
    input  logic              botaoSUB,
    input  logic              botaoMULT,
    input  logic [OPND_W-1:0] numero0,
    input  logic [OPND_W-1:0] numero1,
    output logic [1:0]        op_sel,
    output logic              busy,
    output logic              result_valid,
    output logic              neg,
    output logic              ovf,
    output logic [3:0]        milR,
    output logic [3:0]        cenR,
    output logic [3:0]        decR,
    output logic [3:0]        uniR
);

    localparam logic [4:0] MULT_LAST = 5'(OPND_W - 1);
    localparam logic [4:0] CONV_LAST = 5'(CONV_ITERS - 1);

    logic ev_eq, ev_soma, ev_sub, ev_mult;

    btn_event u_eq   (.clock(clock), .reset(reset), .btn_n(botao),     .pulse(ev_eq));
    btn_event u_soma (.clock(clock), .reset(reset), .btn_n(botaoSOMA), .pulse(ev_soma));
    btn_event u_sub  (.clock(clock), .reset(reset), .btn_n(botaoSUB),  .pulse(ev_sub));
    btn_event u_mult (.clock(clock), .reset(reset), .btn_n(botaoMULT), .pulse(ev_mult));

    state_t                state, state_next;
    logic [4:0]            cnt;
    logic [1:0]            op_lat;
    logic [RES_W-1:0]      a_sh;      // multiplicand, shifted left each mult step
    logic [OPND_W-1:0]     b_sh;      // multiplier, shifted right each mult step
    logic [RES_W-1:0]      r;
    logic [RES_W-1:0]      r_next;
    logic                  neg_calc;
    logic [BCD_W+RES_W-1:0] dd;       // {bcd, binary} double-dabble shift register
    logic [1:0]            op_new;
    logic                  start;

    assign busy = (state != ST_IDLE);

    // Select is resolved before equals so an equals in the same cycle sees the new op.
    always_comb begin
        op_new = op_sel;
        if (state == ST_IDLE) begin
            if (ev_soma)      op_new = (op_sel == OP_SOMA) ? OP_OFF : OP_SOMA;
            else if (ev_sub)  op_new = (op_sel == OP_SUB)  ? OP_OFF : OP_SUB;
            else if (ev_mult) op_new = (op_sel == OP_MULT) ? OP_OFF : OP_MULT;
        end
        start = (state == ST_IDLE) && ev_eq && (op_new != OP_OFF);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start) state_next = ST_CALC;
            ST_CALC: if (op_lat != OP_MULT || cnt == MULT_LAST) state_next = ST_CONV;
            ST_CONV: if (cnt == CONV_LAST) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        r_next = r;
        if (state == ST_CALC) begin
            case (op_lat)
                OP_SOMA: r_next = {7'd0, a_sh[OPND_W-1:0]} + {7'd0, b_sh};
                OP_SUB:  r_next = (a_sh[OPND_W-1:0] >= b_sh)
                                ? {7'd0, a_sh[OPND_W-1:0] - b_sh}
                                : {7'd0, b_sh - a_sh[OPND_W-1:0]};
                OP_MULT: r_next = r + (b_sh[0] ? a_sh : '0);
                default: r_next = r;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_sel       <= OP_OFF;
            result_valid <= 1'b0;
            neg          <= 1'b0;
            ovf          <= 1'b0;
            milR         <= 4'd0;
            cenR         <= 4'd0;
            decR         <= 4'd0;
            uniR         <= 4'd0;
            cnt          <= '0;
            op_lat       <= OP_OFF;
            a_sh         <= '0;
            b_sh         <= '0;
            r            <= '0;
            neg_calc     <= 1'b0;
            dd           <= '0;
        end else begin
            op_sel <= op_new;
            if (op_new != op_sel) result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_lat       <= op_new;
                        a_sh         <= {7'd0, numero0};
                        b_sh         <= numero1;
                        r            <= '0;
                        cnt          <= '0;
                        neg_calc     <= 1'b0;
                        result_valid <= 1'b0;
                        neg          <= 1'b0;
                        ovf          <= 1'b0;
                    end
                end
                ST_CALC: begin
                    r <= r_next;
                    if (op_lat == OP_SUB && a_sh[OPND_W-1:0] < b_sh) neg_calc <= 1'b1;
                    if (state_next == ST_CONV) begin
                        cnt <= '0;
                        dd  <= {{BCD_W{1'b0}}, r_next};
                    end else begin
                        cnt  <= cnt + 5'd1;
                        a_sh <= a_sh << 1;
                        b_sh <= b_sh >> 1;
                    end
                end
                ST_CONV: begin
                    dd  <= {dd_adjust(dd[BCD_W+RES_W-1:RES_W]), dd[RES_W-1:0]} << 1;
                    cnt <= cnt + 5'd1;
                end
                ST_DONE: begin
                    result_valid <= 1'b1;
                    neg          <= neg_calc;
                    if (r > RES_W'(9999)) begin
                        ovf  <= 1'b1;
                        milR <= BLANK_DIGIT;
                        cenR <= BLANK_DIGIT;
                        decR <= BLANK_DIGIT;
                        uniR <= BLANK_DIGIT;
                    end else begin
                        milR <= dd[RES_W+15:RES_W+12];
                        cenR <= dd[RES_W+11:RES_W+8];
                        decR <= dd[RES_W+7:RES_W+4];
                        uniR <= dd[RES_W+3:RES_W];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
